// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one unified memory port between fetch (read-only)
// and the LSU (read/write), one outstanding access at a time, with fetch
// squash on flush, an LSU streak limiter and a response timeout.
module imem_dmem_arbiter #(
  parameter int unsigned LSU_MAX_STREAK = 4,
  parameter int unsigned TIMEOUT_CYC    = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic [31:0] if_rdata,
  output logic        if_rvld,
  input  logic        lsu_req,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wen,
  output logic        lsu_gnt,
  output logic [31:0] lsu_rdata,
  output logic        lsu_rvld,
  output logic        lsu_ready,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wen,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvld,
  output logic        err_timeout
);

  localparam int unsigned STK_W = $clog2(LSU_MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LSU} state_t;

  state_t             state;
  logic [STK_W-1:0]   streak;
  logic               squash;
  logic [CNT_W-1:0]   tcnt;

  logic busy;
  logic issue_ok;
  logic if_ok;
  logic if_win;
  logic lsu_win;
  logic rsp_if;
  logic rsp_lsu;
  logic tmo;

  // Arbitration, response decode and timeout detection
  always_comb begin
    busy     = 1'b0;
    issue_ok = 1'b0;
    if_ok    = 1'b0;
    if_win   = 1'b0;
    lsu_win  = 1'b0;
    rsp_if   = 1'b0;
    rsp_lsu  = 1'b0;
    tmo      = 1'b0;

    busy     = (state != IDLE);
    issue_ok = ~RST & (~busy | mem_rvld);
    if_ok    = if_req & ~if_flush;
    // LSU normally wins; a saturated streak hands the slot to a waiting fetch
    if_win   = issue_ok & if_ok & (~lsu_req | (streak == STK_W'(LSU_MAX_STREAK)));
    lsu_win  = issue_ok & lsu_req & ~if_win;
    rsp_if   = ~RST & mem_rvld & (state == BUSY_IF);
    rsp_lsu  = ~RST & mem_rvld & (state == BUSY_LSU);
    tmo      = ~RST & busy & ~mem_rvld & (tcnt == CNT_W'(TIMEOUT_CYC - 1));
  end

  // Same-cycle grant and memory request mux
  assign if_gnt    = if_win;
  assign lsu_gnt   = lsu_win;
  assign mem_en    = if_win | lsu_win;
  assign mem_addr  = if_win ? if_addr : (lsu_win ? lsu_addr : 32'h0);
  assign mem_wdata = lsu_win ? lsu_wdata : 32'h0;
  assign mem_wen   = lsu_win ? lsu_wen : 4'h0;

  // Response routing; a flush in the return cycle also hides the fetch data
  assign if_rvld   = rsp_if & ~squash & ~if_flush;
  assign if_rdata  = if_rvld ? mem_rdata : 32'h0;
  assign lsu_rvld  = rsp_lsu;
  assign lsu_rdata = rsp_lsu ? mem_rdata : 32'h0;
  assign lsu_ready = RST |
                     (~(lsu_req & ~lsu_win) & ~((state == BUSY_LSU) & ~mem_rvld));

  // Transaction state, streak limiter, squash flag and timeout tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      streak      <= '0;
      squash      <= 1'b0;
      tcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (if_win)
        state <= BUSY_IF;
      else if (lsu_win)
        state <= BUSY_LSU;
      else if ((busy & mem_rvld) | tmo)
        state <= IDLE;

      if (~if_req | if_win)
        streak <= '0;
      else if (lsu_win && (streak != STK_W'(LSU_MAX_STREAK)))
        streak <= streak + 1'b1;

      if (rsp_if | tmo)
        squash <= 1'b0;
      else if (if_flush & (state == BUSY_IF) & ~mem_rvld)
        squash <= 1'b1;

      if (if_win | lsu_win | mem_rvld | tmo | ~busy)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;

      if (tmo)
        err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed scenarios followed by randomized traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_imem_dmem_arbiter;

  localparam int unsigned MAXS = 4;
  localparam int unsigned TO   = 8;
  localparam int unsigned CW   = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req, if_flush, if_gnt, if_rvld;
  logic [31:0] if_addr, if_rdata;
  logic        lsu_req, lsu_gnt, lsu_rvld, lsu_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wen;
  logic        mem_en, mem_rvld, err_timeout;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wen;

  always #5 CLK = ~CLK;

  imem_dmem_arbiter #(.LSU_MAX_STREAK(MAXS), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvld(if_rvld),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wen(lsu_wen),
    .lsu_gnt(lsu_gnt), .lsu_rdata(lsu_rdata), .lsu_rvld(lsu_rvld), .lsu_ready(lsu_ready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata), .mem_rvld(mem_rvld), .err_timeout(err_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner of the outstanding access (0 none, 1 fetch, 2 lsu)
  int m_owner  = 0;
  int m_streak = 0;
  int m_wait   = 0;
  bit m_squash = 0;
  bit m_err    = 0;
  // Memory model: cycles until the response, 0 when nothing is pending
  int mem_lat  = 0;
  int lat_mode = 1;
  bit g_if     = 0;
  bit g_lsu    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle: retire granted requests, drive the memory response
  task automatic tick();
    @(posedge CLK);
    #1;
    if (g_if)  if_req  = 1'b0;
    if (g_lsu) lsu_req = 1'b0;
    mem_rvld  = 1'b0;
    mem_rdata = $urandom;
    if (mem_lat > 0) begin
      mem_lat--;
      if (mem_lat == 0) mem_rvld = 1'b1;
    end
  endtask

  // Compare all outputs against the model mid-cycle, then advance the model
  task automatic eval();
    bit rsp, issue, p_if, p_lsu, e_ifv, e_lsv, e_rdy, tmo;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_wen;
    #3;
    rsp = 0; p_if = 0; p_lsu = 0; e_ifv = 0; e_lsv = 0; e_rdy = 1;
    e_addr = 32'h0; e_wd = 32'h0; e_wen = 4'h0;
    if (!RST) begin
      rsp   = mem_rvld && (m_owner != 0);
      issue = (m_owner == 0) || rsp;
      p_if  = issue && if_req && !if_flush && (!lsu_req || (m_streak == MAXS));
      p_lsu = issue && lsu_req && !p_if;
      if (p_if) e_addr = if_addr;
      if (p_lsu) begin
        e_addr = lsu_addr; e_wd = lsu_wdata; e_wen = lsu_wen;
      end
      e_ifv = rsp && (m_owner == 1) && !m_squash && !if_flush;
      e_lsv = rsp && (m_owner == 2);
      e_rdy = !(lsu_req && !p_lsu) && !((m_owner == 2) && !rsp);
    end
    check_eq("if_gnt",    32'(if_gnt),    32'(p_if));
    check_eq("lsu_gnt",   32'(lsu_gnt),   32'(p_lsu));
    check_eq("mem_en",    32'(mem_en),    32'(p_if | p_lsu));
    check_eq("mem_addr",  mem_addr,       e_addr);
    check_eq("mem_wdata", mem_wdata,      e_wd);
    check_eq("mem_wen",   32'(mem_wen),   32'(e_wen));
    check_eq("if_rvld",   32'(if_rvld),   32'(e_ifv));
    check_eq("if_rdata",  if_rdata,       e_ifv ? mem_rdata : 32'h0);
    check_eq("lsu_rvld",  32'(lsu_rvld),  32'(e_lsv));
    check_eq("lsu_rdata", lsu_rdata,      e_lsv ? mem_rdata : 32'h0);
    check_eq("lsu_ready", 32'(lsu_ready), 32'(e_rdy));
    check_eq("err_to",    32'(err_timeout), 32'(m_err));

    if (RST) begin
      m_owner = 0; m_streak = 0; m_wait = 0; m_squash = 0; m_err = 0; mem_lat = 0;
    end else begin
      tmo = 0;
      if ((m_owner != 0) && !rsp) begin
        m_wait++;
        if (m_wait >= TO) tmo = 1;
      end
      if (tmo || (rsp && (m_owner == 1))) m_squash = 0;
      else if ((m_owner == 1) && if_flush && !mem_rvld) m_squash = 1;
      if (!if_req || p_if) m_streak = 0;
      else if (p_lsu && (m_streak < MAXS)) m_streak++;
      if (p_if || p_lsu) begin
        m_owner = p_if ? 1 : 2;
        m_wait  = 0;
        if (lat_mode != 0) mem_lat = lat_mode;
        else mem_lat = ($urandom % 50 == 0) ? 1000 : int'($urandom_range(1, 4));
      end else if (rsp) begin
        m_owner = 0;
      end else if (tmo) begin
        m_owner = 0; m_err = 1; m_wait = 0; mem_lat = 0;
      end
    end
    g_if  = p_if;
    g_lsu = p_lsu;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      eval();
    end
  endtask

  logic [5:0] seq;

  initial begin
    RST = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
    lsu_req = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wen = 0;
    mem_rvld = 0; mem_rdata = 0;
    idle(2);

    // Single fetch, latency 1
    tick(); RST = 1'b0; lat_mode = 1;
    if_req = 1; if_addr = 32'h100;
    eval();
    check_eq("t1_gnt", 32'(if_gnt), 32'd1);
    check_eq("t1_addr", mem_addr, 32'h100);
    tick(); mem_rdata = 32'h13;
    eval();
    check_eq("t1_rvld", 32'(if_rvld), 32'd1);
    check_eq("t1_rdata", if_rdata, 32'h13);

    // Simultaneous fetch and LSU read: LSU first, fetch issues on LSU return
    tick(); lat_mode = 2;
    if_req = 1; if_addr = 32'h104; lsu_req = 1; lsu_addr = 32'h2000; lsu_wen = 0;
    eval();
    check_eq("t2_lsu_first", 32'(lsu_gnt), 32'd1);
    check_eq("t2_if_wait", 32'(if_gnt), 32'd0);
    tick(); eval();
    check_eq("t2_not_ready", 32'(lsu_ready), 32'd0);
    tick(); eval();
    check_eq("t2_lsu_rvld", 32'(lsu_rvld), 32'd1);
    check_eq("t2_if_on_rsp", 32'(if_gnt), 32'd1);
    idle(4);

    // Streak limiter with both requesters saturating
    lat_mode = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if_req = 1; if_addr = 32'h300 + 32'(i * 4);
      lsu_req = 1; lsu_addr = 32'h3000 + 32'(i * 4);
      eval();
      seq[i] = if_gnt;
    end
    check_eq("t3_seq", 32'(seq), 32'h10);
    tick(); if_req = 0; lsu_req = 0;
    eval();
    idle(3);

    // Flush during a latency-3 fetch squashes its response
    tick(); lat_mode = 3; if_req = 1; if_addr = 32'h200;
    eval();
    tick(); if_flush = 1; eval();
    tick(); if_flush = 0; eval();
    tick(); eval();
    check_eq("t4_squashed", 32'(if_rvld), 32'd0);
    tick(); lat_mode = 1; if_req = 1; if_addr = 32'h204;
    eval();
    tick(); eval();
    check_eq("t4_next_rvld", 32'(if_rvld), 32'd1);

    // LSU partial write
    tick(); lsu_req = 1; lsu_addr = 32'h40; lsu_wdata = 32'hDEADBEEF; lsu_wen = 4'b0011;
    eval();
    check_eq("t5_wen", 32'(mem_wen), 32'h3);
    check_eq("t5_wdata", mem_wdata, 32'hDEADBEEF);
    check_eq("t5_addr", mem_addr, 32'h40);
    tick(); eval();
    check_eq("t5_ack", 32'(lsu_rvld), 32'd1);

    // Memory never answers: timeout, sticky error, late response ignored
    tick(); lat_mode = 1000; lsu_req = 1; lsu_addr = 32'h80; lsu_wen = 0;
    eval();
    idle(TO);
    tick(); mem_rvld = 1;
    eval();
    check_eq("t6_err", 32'(err_timeout), 32'd1);
    check_eq("t6_late_rvld", 32'(lsu_rvld), 32'd0);
    idle(2);
    check_eq("t6_err_sticky", 32'(err_timeout), 32'd1);
    tick(); lsu_req = 1; lsu_addr = 32'h90;
    eval();
    tick(); eval();
    tick(); RST = 1; eval();
    check_eq("t6_rst_ready", 32'(lsu_ready), 32'd1);
    tick(); RST = 0; eval();
    check_eq("t6_err_clr", 32'(err_timeout), 32'd0);
    tick(); mem_rvld = 1; eval();
    check_eq("t6_no_rvld", 32'(lsu_rvld), 32'd0);

    // Randomized traffic
    lat_mode = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      RST = ($urandom % 150 == 0);
      if (!if_req && ($urandom % 3 == 0)) begin
        if_req = 1; if_addr = $urandom;
      end
      if_flush = ($urandom % 8 == 0);
      if (!lsu_req && ($urandom % 3 == 0)) begin
        lsu_req = 1; lsu_addr = $urandom; lsu_wdata = $urandom;
        lsu_wen = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
      end
      if ((m_owner == 0) && ($urandom % 12 == 0)) mem_rvld = 1;
      eval();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
